// File: rtl/tx_scheduler_if.sv
// Register-bank / PHY side signals of the PD transmit scheduler.
// master = register bank and PHY model, slave = tx_scheduler.
interface tx_scheduler_if;
    logic [7:0]  ioTRANSMIT;
    logic        TRANSMIT_WR;
    logic        RX_BUSY;
    logic        PHY_ACK;
    logic        PHY_NACK;
    logic [15:0] ALERT_CLR;
    logic        oPHY_REQ;
    logic [2:0]  oPHY_TYPE;
    logic [7:0]  oTRANSMIT;
    logic [15:0] ALERT;
    logic        oBUSY;
    logic [1:0]  oRETRY_CNT;

    modport master (
        output ioTRANSMIT, TRANSMIT_WR, RX_BUSY, PHY_ACK, PHY_NACK, ALERT_CLR,
        input  oPHY_REQ, oPHY_TYPE, oTRANSMIT, ALERT, oBUSY, oRETRY_CNT
    );

    modport slave (
        input  ioTRANSMIT, TRANSMIT_WR, RX_BUSY, PHY_ACK, PHY_NACK, ALERT_CLR,
        output oPHY_REQ, oPHY_TYPE, oTRANSMIT, ALERT, oBUSY, oRETRY_CNT
    );
endinterface

// File: rtl/tx_scheduler.sv
// TCPC transmit scheduler: TRANSMIT command sequencing, retries, RX arbitration, ALERT reporting.
// Optional macro TX_BIST_EN: accept type 7 as a BIST carrier request.
module tx_scheduler #(
    parameter int ACK_TIMEOUT = 64,
    parameter int RETRY_GAP   = 8
) (
    input  logic          CLK,
    input  logic          reset,
    tx_scheduler_if.slave bus
);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam int GW = $clog2(RETRY_GAP) + 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
    // The ARB cycle is part of the gap, so GAP itself lasts RETRY_GAP-1 cycles.
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 2);
    localparam logic [15:0] TX_FAILED    = 16'h0010;
    localparam logic [15:0] TX_DISCARDED = 16'h0020;
    localparam logic [15:0] TX_SUCCESS   = 16'h0040;

    typedef enum logic [2:0] {IDLE, ARB, SEND, GAP, RST_SEND} state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [GW-1:0] gap_r;

    logic [2:0]  wr_type_s;
    logic [2:0]  cur_type_s;
    logic        accept_sop_s;
    logic        is_bist_s;
    logic        hr_abort_s;
    logic        timeout_s;
    logic [15:0] alert_kept_s;

    // Command decode, abort detection and ALERT clear mask.
    always_comb begin
        wr_type_s  = bus.ioTRANSMIT[2:0];
        cur_type_s = bus.oTRANSMIT[2:0];
`ifdef TX_BIST_EN
        accept_sop_s = (wr_type_s <= 3'd2) || (wr_type_s == 3'd7);
        is_bist_s    = (cur_type_s == 3'd7);
`else
        accept_sop_s = (wr_type_s <= 3'd2);
        is_bist_s    = 1'b0;
`endif
        hr_abort_s   = bus.TRANSMIT_WR && (wr_type_s == 3'd5);
        timeout_s    = (timer_r == TMR_LAST) && !is_bist_s;
        alert_kept_s = bus.ALERT & ~bus.ALERT_CLR;
    end

    // Scheduler FSM with registered PHY and ALERT outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            timer_r        <= '0;
            gap_r          <= '0;
            bus.oPHY_REQ   <= 1'b0;
            bus.oPHY_TYPE  <= 3'd0;
            bus.oTRANSMIT  <= 8'd0;
            bus.ALERT      <= 16'd0;
            bus.oBUSY      <= 1'b0;
            bus.oRETRY_CNT <= 2'd0;
        end else begin
            bus.ALERT <= alert_kept_s;
            case (state_r)
                IDLE: begin
                    timer_r <= '0;
                    gap_r   <= '0;
                    if (bus.TRANSMIT_WR && (wr_type_s == 3'd5 || wr_type_s == 3'd6)) begin
                        state_r        <= RST_SEND;
                        bus.oTRANSMIT  <= bus.ioTRANSMIT;
                        bus.oRETRY_CNT <= bus.ioTRANSMIT[5:4];
                        bus.oBUSY      <= 1'b1;
                    end else if (bus.TRANSMIT_WR && accept_sop_s) begin
                        state_r        <= ARB;
                        bus.oTRANSMIT  <= bus.ioTRANSMIT;
                        bus.oRETRY_CNT <= (wr_type_s == 3'd7) ? 2'd0 : bus.ioTRANSMIT[5:4];
                        bus.oBUSY      <= 1'b1;
                    end else if (bus.TRANSMIT_WR) begin
                        bus.ALERT <= alert_kept_s | TX_FAILED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARB, SEND, GAP: begin
                    if (hr_abort_s) begin
                        // Dropping oPHY_REQ here gives the PHY one low cycle before the reset request.
                        state_r        <= RST_SEND;
                        bus.ALERT      <= alert_kept_s | TX_DISCARDED;
                        bus.oTRANSMIT  <= bus.ioTRANSMIT;
                        bus.oRETRY_CNT <= bus.ioTRANSMIT[5:4];
                        bus.oPHY_REQ   <= 1'b0;
                    end else if (state_r == ARB) begin
                        if (bus.RX_BUSY) begin
                            state_r       <= IDLE;
                            bus.ALERT     <= alert_kept_s | TX_DISCARDED;
                            bus.oTRANSMIT <= 8'd0;
                            bus.oBUSY     <= 1'b0;
                        end else begin
                            state_r       <= SEND;
                            timer_r       <= '0;
                            bus.oPHY_REQ  <= 1'b1;
                            bus.oPHY_TYPE <= cur_type_s;
                        end
                    end else if (state_r == GAP) begin
                        if (gap_r >= GAP_LAST) begin
                            state_r <= ARB;
                        end else begin
                            gap_r <= gap_r + 1'b1;
                        end
                    end else if (bus.PHY_ACK || bus.PHY_NACK || timeout_s) begin
                        bus.oPHY_REQ <= 1'b0;
                        if (bus.PHY_ACK || is_bist_s || bus.oRETRY_CNT == 2'd0) begin
                            state_r       <= IDLE;
                            bus.ALERT     <= alert_kept_s |
                                ((bus.PHY_ACK || is_bist_s) ? TX_SUCCESS : TX_FAILED);
                            bus.oPHY_TYPE <= 3'd0;
                            bus.oTRANSMIT <= 8'd0;
                            bus.oBUSY     <= 1'b0;
                        end else begin
                            state_r        <= GAP;
                            gap_r          <= '0;
                            bus.oRETRY_CNT <= bus.oRETRY_CNT - 2'd1;
                        end
                    end else if (timer_r != {TW{1'b1}}) begin
                        timer_r <= timer_r + 1'b1;
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                RST_SEND: begin
                    if (!bus.oPHY_REQ) begin
                        bus.oPHY_REQ  <= 1'b1;
                        bus.oPHY_TYPE <= cur_type_s;
                    end else if (bus.PHY_ACK || bus.PHY_NACK) begin
                        state_r       <= IDLE;
                        bus.ALERT     <= alert_kept_s | TX_SUCCESS | TX_FAILED;
                        bus.oPHY_REQ  <= 1'b0;
                        bus.oPHY_TYPE <= 3'd0;
                        bus.oTRANSMIT <= 8'd0;
                        bus.oBUSY     <= 1'b0;
                    end else begin
                        state_r <= RST_SEND;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    bus.oPHY_REQ  <= 1'b0;
                    bus.oPHY_TYPE <= 3'd0;
                    bus.oTRANSMIT <= 8'd0;
                    bus.oBUSY     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_scheduler.sv
// Scenario bench for tx_scheduler: expected PHY requests are queued when commands are written
// and popped when oPHY_REQ rises; ALERT/busy expectations are checked inline.
module tb_tx_scheduler;
    logic CLK = 1'b0;
    logic reset;
    tx_scheduler_if bus();

    tx_scheduler #(.ACK_TIMEOUT(64), .RETRY_GAP(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] ptype;
        logic [1:0] retry;
    } req_t;

    req_t exp_q[$];
    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic write_cmd(input logic [7:0] v);
        @(negedge CLK);
        bus.ioTRANSMIT  = v;
        bus.TRANSMIT_WR = 1'b1;
        @(negedge CLK);
        bus.TRANSMIT_WR = 1'b0;
    endtask

    task automatic clear_alert();
        @(negedge CLK);
        bus.ALERT_CLR = 16'hFFFF;
        @(negedge CLK);
        bus.ALERT_CLR = 16'h0000;
    endtask

    task automatic wait_req(input int budget, output int low, output bit ok);
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.oPHY_REQ === 1'b1) begin
                ok = 1'b1;
                return;
            end
            low++;
            @(negedge CLK);
        end
    endtask

    task automatic pop_exp(output req_t e);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            e.ptype = 3'bxxx;
            e.retry = 2'bxx;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({bus.oPHY_REQ, bus.oPHY_TYPE, bus.oTRANSMIT, bus.ALERT, bus.oBUSY, bus.oRETRY_CNT} !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b type=%0d tx=%h alert=%h busy=%b rc=%0d, want all 0",
                     bus.oPHY_REQ, bus.oPHY_TYPE, bus.oTRANSMIT, bus.ALERT, bus.oBUSY, bus.oRETRY_CNT);
        end
        reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_ack();
        int low; bit ok; req_t e;
        exp_q.push_back('{ptype: 3'd0, retry: 2'd1});
        write_cmd(8'h10);
        total++;
        if (bus.oPHY_REQ !== 1'b0 || bus.oBUSY !== 1'b1 || bus.oTRANSMIT !== 8'h10) begin
            bad++;
            $display("FAIL ack_write_plus1: got req=%b busy=%b tx=%h, want req=0 busy=1 tx=10",
                     bus.oPHY_REQ, bus.oBUSY, bus.oTRANSMIT);
        end
        @(negedge CLK);
        total++;
        if (bus.oPHY_REQ !== 1'b1) begin
            bad++;
            $display("FAIL ack_latency: got req=%b at write+2, want 1", bus.oPHY_REQ);
        end
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL ack_request: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                     ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        repeat (5) @(negedge CLK);
        bus.PHY_ACK = 1'b1;
        @(negedge CLK);
        bus.PHY_ACK = 1'b0;
        total++;
        if (bus.ALERT !== 16'h0040 || bus.oBUSY !== 1'b0 || bus.oPHY_REQ !== 1'b0 || bus.oTRANSMIT !== 8'h00) begin
            bad++;
            $display("FAIL ack_done: got alert=%h busy=%b req=%b tx=%h, want alert=0040 busy=0 req=0 tx=00",
                     bus.ALERT, bus.oBUSY, bus.oPHY_REQ, bus.oTRANSMIT);
        end
        clear_alert();
        total++;
        if (bus.ALERT !== 16'h0000) begin
            bad++;
            $display("FAIL ack_clear: got alert=%h, want 0000", bus.ALERT);
        end
    endtask

    task automatic test_ack_nack_tie();
        int low; bit ok; req_t e;
        exp_q.push_back('{ptype: 3'd2, retry: 2'd1});
        write_cmd(8'h12);
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL tie_request: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                     ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        bus.PHY_ACK  = 1'b1;
        bus.PHY_NACK = 1'b1;
        @(negedge CLK);
        bus.PHY_ACK  = 1'b0;
        bus.PHY_NACK = 1'b0;
        total++;
        if (bus.ALERT !== 16'h0040 || bus.oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL tie_ack_wins: got alert=%h busy=%b, want alert=0040 busy=0", bus.ALERT, bus.oBUSY);
        end
        clear_alert();
    endtask

    task automatic test_retry();
        int low; bit ok; req_t e;
        for (int r = 3; r >= 0; r--) exp_q.push_back('{ptype: 3'd1, retry: 2'(r)});
        write_cmd(8'h31);
        for (int a = 0; a < 4; a++) begin
            wait_req(30, low, ok);
            pop_exp(e);
            total++;
            if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
                bad++;
                $display("FAIL retry_request%0d: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                         a, ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
            end
            if (a > 0) begin
                total++;
                if (low !== 8) begin
                    bad++;
                    $display("FAIL retry_gap%0d: got %0d low cycles, want 8", a, low);
                end
            end
            bus.PHY_NACK = 1'b1;
            @(negedge CLK);
            bus.PHY_NACK = 1'b0;
        end
        total++;
        if (bus.ALERT !== 16'h0010 || bus.oBUSY !== 1'b0 || bus.oPHY_REQ !== 1'b0) begin
            bad++;
            $display("FAIL retry_final: got alert=%h busy=%b req=%b, want alert=0010 busy=0 req=0",
                     bus.ALERT, bus.oBUSY, bus.oPHY_REQ);
        end
        clear_alert();
    endtask

    task automatic test_discard();
        bus.RX_BUSY = 1'b1;
        write_cmd(8'h00);
        @(negedge CLK);
        total++;
        if (bus.oPHY_REQ !== 1'b0 || bus.ALERT !== 16'h0020 || bus.oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL discard: got req=%b alert=%h busy=%b, want req=0 alert=0020 busy=0",
                     bus.oPHY_REQ, bus.ALERT, bus.oBUSY);
        end
        bus.RX_BUSY   = 1'b0;
        bus.ALERT_CLR = 16'h0020;
        @(negedge CLK);
        bus.ALERT_CLR = 16'h0000;
        total++;
        if (bus.ALERT !== 16'h0000) begin
            bad++;
            $display("FAIL discard_clear: got alert=%h, want 0000", bus.ALERT);
        end
    endtask

    task automatic test_hard_reset_abort();
        int low; bit ok; req_t e;
        exp_q.push_back('{ptype: 3'd0, retry: 2'd1});
        write_cmd(8'h10);
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL hr_first_request: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                     ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        repeat (2) @(negedge CLK);
        exp_q.push_back('{ptype: 3'd5, retry: 2'd0});
        write_cmd(8'h05);
        total++;
        if (bus.oPHY_REQ !== 1'b0 || bus.ALERT !== 16'h0020 || bus.oTRANSMIT !== 8'h05) begin
            bad++;
            $display("FAIL hr_abort: got req=%b alert=%h tx=%h, want req=0 alert=0020 tx=05",
                     bus.oPHY_REQ, bus.ALERT, bus.oTRANSMIT);
        end
        wait_req(10, low, ok);
        pop_exp(e);
        total++;
        if (!ok || low !== 1 || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL hr_request: got ok=%b low=%0d type=%0d rc=%0d, want low=1 type=%0d rc=%0d",
                     ok, low, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        bus.PHY_ACK = 1'b1;
        @(negedge CLK);
        bus.PHY_ACK = 1'b0;
        total++;
        if (bus.ALERT !== 16'h0070 || bus.oBUSY !== 1'b0 || bus.oPHY_REQ !== 1'b0) begin
            bad++;
            $display("FAIL hr_done: got alert=%h busy=%b req=%b, want alert=0070 busy=0 req=0",
                     bus.ALERT, bus.oBUSY, bus.oPHY_REQ);
        end
        clear_alert();
    endtask

    task automatic test_timeout();
        int low; int hi; bit ok; req_t e;
        exp_q.push_back('{ptype: 3'd0, retry: 2'd0});
        write_cmd(8'h00);
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL timeout_request: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                     ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        hi = 0;
        while (bus.oPHY_REQ === 1'b1 && hi < 100) begin
            bus.ioTRANSMIT  = 8'h01;
            bus.TRANSMIT_WR = (hi == 10);
            hi++;
            @(negedge CLK);
        end
        bus.TRANSMIT_WR = 1'b0;
        total++;
        if (hi !== 64) begin
            bad++;
            $display("FAIL timeout_length: got %0d high cycles, want 64", hi);
        end
        total++;
        if (bus.ALERT !== 16'h0010 || bus.oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL timeout_alert: got alert=%h busy=%b, want alert=0010 busy=0", bus.ALERT, bus.oBUSY);
        end
        clear_alert();
        exp_q.push_back('{ptype: 3'd0, retry: 2'd0});
        write_cmd(8'h00);
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype) begin
            bad++;
            $display("FAIL reset_mid_request: got ok=%b type=%0d, want type=%0d", ok, bus.oPHY_TYPE, e.ptype);
        end
        repeat (10) @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.oPHY_REQ, bus.oPHY_TYPE, bus.oTRANSMIT, bus.ALERT, bus.oBUSY, bus.oRETRY_CNT} !== 31'd0) begin
            bad++;
            $display("FAIL async_reset: got req=%b type=%0d tx=%h alert=%h busy=%b rc=%0d, want all 0",
                     bus.oPHY_REQ, bus.oPHY_TYPE, bus.oTRANSMIT, bus.ALERT, bus.oBUSY, bus.oRETRY_CNT);
        end
        @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (bus.ALERT !== 16'h0000 || bus.oPHY_REQ !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: got alert=%h req=%b, want alert=0000 req=0", bus.ALERT, bus.oPHY_REQ);
        end
    endtask

    task automatic test_reject();
        bit seen;
        @(negedge CLK);
        bus.ioTRANSMIT  = 8'h03;
        bus.TRANSMIT_WR = 1'b1;
        bus.ALERT_CLR   = 16'h0010;
        @(negedge CLK);
        bus.TRANSMIT_WR = 1'b0;
        bus.ALERT_CLR   = 16'h0000;
        total++;
        if (bus.ALERT !== 16'h0010 || bus.oBUSY !== 1'b0 || bus.oTRANSMIT !== 8'h00) begin
            bad++;
            $display("FAIL reject3_set_wins: got alert=%h busy=%b tx=%h, want alert=0010 busy=0 tx=00",
                     bus.ALERT, bus.oBUSY, bus.oTRANSMIT);
        end
        clear_alert();
        write_cmd(8'h04);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.oPHY_REQ !== 1'b0) seen = 1'b1;
            @(negedge CLK);
        end
        total++;
        if (seen !== 1'b0 || bus.ALERT !== 16'h0010) begin
            bad++;
            $display("FAIL reject4: got req_seen=%b alert=%h, want req_seen=0 alert=0010", seen, bus.ALERT);
        end
        clear_alert();
    endtask

    task automatic test_bist();
`ifdef TX_BIST_EN
        int low; bit ok; req_t e;
        exp_q.push_back('{ptype: 3'd7, retry: 2'd0});
        write_cmd(8'h37);
        wait_req(20, low, ok);
        pop_exp(e);
        total++;
        if (!ok || bus.oPHY_TYPE !== e.ptype || bus.oRETRY_CNT !== e.retry) begin
            bad++;
            $display("FAIL bist_request: got ok=%b type=%0d rc=%0d, want type=%0d rc=%0d",
                     ok, bus.oPHY_TYPE, bus.oRETRY_CNT, e.ptype, e.retry);
        end
        repeat (80) @(negedge CLK);
        total++;
        if (bus.oPHY_REQ !== 1'b1) begin
            bad++;
            $display("FAIL bist_no_timeout: got req=%b after 80 cycles, want 1", bus.oPHY_REQ);
        end
        bus.PHY_ACK = 1'b1;
        @(negedge CLK);
        bus.PHY_ACK = 1'b0;
        total++;
        if (bus.ALERT !== 16'h0040 || bus.oBUSY !== 1'b0) begin
            bad++;
            $display("FAIL bist_done: got alert=%h busy=%b, want alert=0040 busy=0", bus.ALERT, bus.oBUSY);
        end
`else
        bit seen;
        write_cmd(8'h07);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.oPHY_REQ !== 1'b0 || bus.oBUSY !== 1'b0) seen = 1'b1;
            @(negedge CLK);
        end
        total++;
        if (seen !== 1'b0 || bus.ALERT !== 16'h0010) begin
            bad++;
            $display("FAIL bist_disabled: got activity=%b alert=%h, want activity=0 alert=0010", seen, bus.ALERT);
        end
`endif
        clear_alert();
    endtask

    initial begin
        reset           = 1'b1;
        bus.ioTRANSMIT  = 8'h00;
        bus.TRANSMIT_WR = 1'b0;
        bus.RX_BUSY     = 1'b0;
        bus.PHY_ACK     = 1'b0;
        bus.PHY_NACK    = 1'b0;
        bus.ALERT_CLR   = 16'h0000;
        test_reset();
        test_ack();
        test_ack_nack_tie();
        test_retry();
        test_discard();
        test_hard_reset_abort();
        test_timeout();
        test_reject();
        test_bist();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending requests, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
